// File: rtl/gpu_alu_pkg.sv
// Shared opcode, state and flag definitions for the execute-stage ALU.
// Latency: n/a (types and helpers only).
// Backpressure: n/a.
package gpu_alu_pkg;

    typedef enum logic [2:0] {
        OP_ADD  = 3'b000,
        OP_SUB  = 3'b011,
        OP_MUL  = 3'b100,
        OP_CONV = 3'b101
    } alu_op_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_CONV,
        S_SAT
    } exec_state_e;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    // Lane counter width; a single lane still needs one bit to index.
    function automatic int cnt_w(input int lanes);
        return (lanes > 1) ? $clog2(lanes) : 1;
    endfunction

    // Place the four condition bits at their architectural positions.
    function automatic logic [3:0] pack_flags(input logic n, input logic z,
                                              input logic c, input logic v);
        logic [3:0] f;
        f         = '0;
        f[FLAG_N] = n;
        f[FLAG_Z] = z;
        f[FLAG_C] = c;
        f[FLAG_V] = v;
        return f;
    endfunction

endpackage

// File: rtl/alu_exec_unit_conv_mac.sv
// Per-lane convolution MAC: unsigned pixel x signed coefficient into a signed accumulator.
// Latency: accumulator updates on the enable edge; sat_o is combinational from acc + current lane.
// Backpressure: none, sequenced entirely by the parent's lane counter.
module conv_mac
    import gpu_alu_pkg::*;
#(
    parameter int LANE_W = 8,
    parameter int LANES  = 4,
    parameter int SHIFT  = 4,
    localparam int ACC_W = 2*LANE_W + $clog2(LANES) + 1,
    localparam int CNT_W = cnt_w(LANES)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      clr_i,
    input  logic                      en_i,
    input  logic [CNT_W-1:0]          lane_sel_i,
    input  logic [LANES*LANE_W-1:0]   pix_i,
    input  logic [LANES*LANE_W-1:0]   coef_i,
    output logic [LANE_W-1:0]         sat_o
);

    localparam int PROD_W = 2*LANE_W + 1;

    logic        [LANE_W-1:0] pix_lane;
    logic        [LANE_W-1:0] coef_lane;
    logic signed [PROD_W-1:0] pix_x;
    logic signed [PROD_W-1:0] coef_x;
    logic signed [PROD_W-1:0] prod;
    logic signed [ACC_W-1:0]  acc_q;
    logic signed [ACC_W-1:0]  acc_sum;
    logic signed [ACC_W-1:0]  acc_shr;

    // Select the current lane, form its product and the running sum including it.
    always_comb begin
        pix_lane  = pix_i[lane_sel_i*LANE_W +: LANE_W];
        coef_lane = coef_i[lane_sel_i*LANE_W +: LANE_W];
        pix_x     = signed'({{(LANE_W+1){1'b0}}, pix_lane});
        coef_x    = signed'({{(LANE_W+1){coef_lane[LANE_W-1]}}, coef_lane});
        prod      = pix_x * coef_x;
        acc_sum   = acc_q + signed'({{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod});
    end

    // Normalise then clamp into the unsigned pixel range.
    always_comb begin
        acc_shr = acc_sum >>> SHIFT;
        if (acc_shr[ACC_W-1]) begin
            sat_o = '0;
        end else if (|acc_shr[ACC_W-2:LANE_W]) begin
            sat_o = '1;
        end else begin
            sat_o = acc_shr[LANE_W-1:0];
        end
    end

    // Accumulator: clear wins over accumulate.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
        end else if (clr_i) begin
            acc_q <= '0;
        end else if (en_i) begin
            acc_q <= acc_sum;
        end
    end

endmodule

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: ADD/MOV/SUB single cycle, MUL two cycles, CONV per-lane MAC with saturation.
// Latency: ADD/SUB/illegal T+1, MUL T+2, CONV T+LANES+1 (result and out_valid registered).
// Backpressure: in_ready low while MUL/CONV in flight; out_valid is a one-cycle pulse, never stalled.
module alu_exec_unit
    import gpu_alu_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int LANE_W = 8,
    parameter int SHIFT  = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       alu_control,
    input  logic             src_a,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             flush,
    output logic             out_valid,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       flags,
    output logic             illegal,
    output logic             stall_o
);

    localparam int LANES = WIDTH / LANE_W;
    localparam int CNT_W = cnt_w(LANES);

    exec_state_e      state_q, state_d;
    logic [CNT_W-1:0] k_q, k_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [3:0]       flags_q, flags_d;
    logic             out_valid_q, out_valid_d;
    logic             illegal_q, illegal_d;
    logic             mac_clr, mac_en;

    logic [WIDTH-1:0] a_eff;
    logic [WIDTH:0]   add_full, sub_full;
    logic             add_v, sub_v;
    logic [WIDTH-1:0] mul_lo;
    logic [LANE_W-1:0] sat;

    assign in_ready = (state_q == S_IDLE);
    assign stall_o  = ~in_ready;

    // Single-cycle datapath on the live operands; MUL works from the captured copies.
    assign a_eff    = src_a ? '0 : op_a;
    assign add_full = {1'b0, a_eff} + {1'b0, op_b};
    assign sub_full = {1'b0, a_eff} + {1'b0, ~op_b} + {{WIDTH{1'b0}}, 1'b1};
    assign add_v    = (a_eff[WIDTH-1] == op_b[WIDTH-1]) && (add_full[WIDTH-1] != a_eff[WIDTH-1]);
    assign sub_v    = (a_eff[WIDTH-1] != op_b[WIDTH-1]) && (sub_full[WIDTH-1] != a_eff[WIDTH-1]);
    assign mul_lo   = a_q * b_q;

    conv_mac #(
        .LANE_W (LANE_W),
        .LANES  (LANES),
        .SHIFT  (SHIFT)
    ) u_conv_mac (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr_i      (mac_clr),
        .en_i       (mac_en),
        .lane_sel_i (k_q),
        .pix_i      (a_q),
        .coef_i     (b_q),
        .sat_o      (sat)
    );

    // Next-state, operand capture and result formation; flush overrides everything.
    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        a_d         = a_q;
        b_d         = b_q;
        result_d    = result_q;
        flags_d     = flags_q;
        out_valid_d = 1'b0;
        illegal_d   = 1'b0;
        mac_clr     = 1'b0;
        mac_en      = 1'b0;
        if (flush) begin
            state_d = S_IDLE;
            k_d     = '0;
            mac_clr = 1'b1;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        case (alu_op_e'(alu_control))
                            OP_ADD: begin
                                result_d    = add_full[WIDTH-1:0];
                                flags_d     = pack_flags(add_full[WIDTH-1], add_full[WIDTH-1:0] == '0,
                                                         add_full[WIDTH], add_v);
                                out_valid_d = 1'b1;
                            end
                            OP_SUB: begin
                                result_d    = sub_full[WIDTH-1:0];
                                flags_d     = pack_flags(sub_full[WIDTH-1], sub_full[WIDTH-1:0] == '0,
                                                         sub_full[WIDTH], sub_v);
                                out_valid_d = 1'b1;
                            end
                            OP_MUL: begin
                                a_d     = a_eff;
                                b_d     = op_b;
                                state_d = S_MUL;
                            end
                            OP_CONV: begin
                                // Pixels are taken raw: zeroing operand A makes no sense for CONV.
                                a_d     = op_a;
                                b_d     = op_b;
                                k_d     = '0;
                                mac_clr = 1'b1;
                                state_d = (LANES == 1) ? S_SAT : S_CONV;
                            end
                            default: begin
                                result_d    = '0;
                                flags_d     = '0;
                                illegal_d   = 1'b1;
                                out_valid_d = 1'b1;
                            end
                        endcase
                    end
                end
                S_MUL: begin
                    result_d    = mul_lo;
                    flags_d     = pack_flags(mul_lo[WIDTH-1], mul_lo == '0, 1'b0, 1'b0);
                    out_valid_d = 1'b1;
                    state_d     = S_IDLE;
                end
                S_CONV: begin
                    // Lanes 0..LANES-2 accumulate here; the last lane is folded into SAT.
                    mac_en = 1'b1;
                    k_d    = k_q + 1'b1;
                    if (k_q == CNT_W'(LANES - 2)) begin
                        state_d = S_SAT;
                    end
                end
                S_SAT: begin
                    result_d    = {{(WIDTH-LANE_W){1'b0}}, sat};
                    flags_d     = pack_flags(1'b0, sat == '0, 1'b0, 1'b0);
                    out_valid_d = 1'b1;
                    k_d         = '0;
                    mac_clr     = 1'b1;
                    state_d     = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // State, operand and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            k_q         <= '0;
            a_q         <= '0;
            b_q         <= '0;
            result_q    <= '0;
            flags_q     <= '0;
            out_valid_q <= 1'b0;
            illegal_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            a_q         <= a_d;
            b_q         <= b_d;
            result_q    <= result_d;
            flags_q     <= flags_d;
            out_valid_q <= out_valid_d;
            illegal_q   <= illegal_d;
        end
    end

    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign flags     = flags_q;
    assign illegal   = illegal_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: directed vector table, hand sequences, random vs model.
// Latency: checks exact out_valid cycle per opcode.
// Backpressure: waits on in_ready before each issue.
module tb_alu_exec_unit;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  alu_control;
    logic        src_a;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        flush;
    logic        out_valid;
    logic [31:0] result;
    logic [3:0]  flags;
    logic        illegal;
    logic        stall_o;

    int tests = 0;
    int fails = 0;

    alu_exec_unit #(.WIDTH(32), .LANE_W(8), .SHIFT(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .alu_control (alu_control),
        .src_a       (src_a),
        .op_a        (op_a),
        .op_b        (op_b),
        .flush       (flush),
        .out_valid   (out_valid),
        .result      (result),
        .flags       (flags),
        .illegal     (illegal),
        .stall_o     (stall_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Reference model from the arithmetic definitions, not from any datapath structure.
    function automatic void model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                  input logic sa, output logic [31:0] r, output logic [3:0] f,
                                  output logic ill, output int lat);
        logic [31:0] ae;
        longint ua, ub, sa_s, sb_s, s, ss;
        int acc, pix, coef, sh;
        ae   = sa ? 32'd0 : a;
        ua   = longint'(ae);
        ub   = longint'(b);
        sa_s = longint'($signed(ae));
        sb_s = longint'($signed(b));
        r = 32'd0; f = 4'd0; ill = 1'b0; lat = 1;
        case (op)
            3'b000: begin
                s  = ua + ub;
                ss = sa_s + sb_s;
                r  = 32'(s);
                f  = {r[31], r == 32'd0, s > 64'sd4294967295, (ss > 64'sd2147483647) || (ss < -64'sd2147483648)};
            end
            3'b011: begin
                s  = ua - ub;
                ss = sa_s - sb_s;
                r  = 32'(s);
                f  = {r[31], r == 32'd0, ua >= ub, (ss > 64'sd2147483647) || (ss < -64'sd2147483648)};
            end
            3'b100: begin
                r   = 32'(ua * ub);
                f   = {r[31], r == 32'd0, 1'b0, 1'b0};
                lat = 2;
            end
            3'b101: begin
                acc = 0;
                for (int i = 0; i < 4; i++) begin
                    pix  = int'(a[8*i +: 8]);
                    coef = int'($signed(b[8*i +: 8]));
                    acc += pix * coef;
                end
                sh = (acc >= 0) ? acc / 16 : -((-acc + 15) / 16);
                if (sh < 0) sh = 0;
                if (sh > 255) sh = 255;
                r   = 32'(sh);
                f   = {1'b0, r == 32'd0, 1'b0, 1'b0};
                lat = 5;
            end
            default: begin
                ill = 1'b1;
            end
        endcase
    endfunction

    // Issue one op (called at a negedge) and check latency, stall window and registered outputs.
    task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic sa, input logic [31:0] er, input logic [3:0] ef,
                         input logic ei, input int lat, input string nm);
        int guard;
        int cyc;
        logic stall_bad;
        guard = 0;
        while (!in_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        in_valid = 1'b1; alu_control = op; op_a = a; op_b = b; src_a = sa;
        @(negedge clk);
        in_valid = 1'b0; op_a = $urandom; op_b = $urandom; src_a = ~sa;
        cyc = 1;
        stall_bad = 1'b0;
        while (!out_valid && cyc < 20) begin
            if (!stall_o) stall_bad = 1'b1;
            @(negedge clk);
            cyc++;
        end
        check({nm, " latency"}, 64'(cyc), 64'(lat));
        check({nm, " result"}, 64'(result), 64'(er));
        check({nm, " flags"}, 64'(flags), 64'(ef));
        check({nm, " illegal"}, 64'(illegal), 64'(ei));
        check({nm, " stall"}, 64'(stall_bad), 64'd0);
        check({nm, " ready_after"}, 64'(in_ready), 64'd1);
    endtask

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic        sa;
        logic [31:0] res;
        logic [3:0]  flg;
        logic        ill;
        int          lat;
        string       nm;
    } vec_t;

    vec_t vecs[14];

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 5))
            0:       return 32'h0000_0000;
            1:       return 32'h7FFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'hFFFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [31:0] er;
        logic [3:0]  ef;
        logic        ei;
        int          lat;
        logic [2:0]  op;
        logic [31:0] a, b;
        logic        sa;
        logic        seen;
        logic [2:0]  ill_ops [4];

        vecs[0]  = '{3'b000, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 4'b1001, 1'b0, 1, "add_ovf"};
        vecs[1]  = '{3'b000, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 4'b0110, 1'b0, 1, "add_carry"};
        vecs[2]  = '{3'b011, 32'h0000_0005, 32'h0000_0005, 1'b0, 32'h0000_0000, 4'b0110, 1'b0, 1, "sub_eq"};
        vecs[3]  = '{3'b011, 32'h0000_0003, 32'h0000_0005, 1'b0, 32'hFFFF_FFFE, 4'b1000, 1'b0, 1, "sub_borrow"};
        vecs[4]  = '{3'b011, 32'h8000_0000, 32'h0000_0001, 1'b0, 32'h7FFF_FFFF, 4'b0011, 1'b0, 1, "sub_ovf"};
        vecs[5]  = '{3'b000, 32'h0000_1234, 32'hDEAD_BEEF, 1'b1, 32'hDEAD_BEEF, 4'b1000, 1'b0, 1, "mov"};
        vecs[6]  = '{3'b100, 32'h0001_0000, 32'h0001_0003, 1'b0, 32'h0003_0000, 4'b0000, 1'b0, 2, "mul"};
        vecs[7]  = '{3'b100, 32'hFFFF_FFFF, 32'h0000_0002, 1'b0, 32'hFFFF_FFFE, 4'b1000, 1'b0, 2, "mul_neg"};
        vecs[8]  = '{3'b100, 32'h0000_0007, 32'h0000_0009, 1'b1, 32'h0000_0000, 4'b0100, 1'b0, 2, "mul_srca"};
        vecs[9]  = '{3'b101, 32'h1020_3040, 32'h0102_0304, 1'b1, 32'h0000_001E, 4'b0000, 1'b0, 5, "conv_nom"};
        vecs[10] = '{3'b101, 32'hFFFF_FFFF, 32'h7F7F_7F7F, 1'b0, 32'h0000_00FF, 4'b0000, 1'b0, 5, "conv_sat_hi"};
        vecs[11] = '{3'b101, 32'h0101_0101, 32'hFFFF_FFFF, 1'b0, 32'h0000_0000, 4'b0100, 1'b0, 5, "conv_sat_lo"};
        vecs[12] = '{3'b110, 32'h1111_1111, 32'h2222_2222, 1'b0, 32'h0000_0000, 4'b0000, 1'b1, 1, "ill_110"};
        vecs[13] = '{3'b001, 32'h0000_0001, 32'h0000_0001, 1'b0, 32'h0000_0000, 4'b0000, 1'b1, 1, "ill_001"};
        ill_ops[0] = 3'b001; ill_ops[1] = 3'b010; ill_ops[2] = 3'b110; ill_ops[3] = 3'b111;

        rst_n = 1'b0; in_valid = 1'b0; alu_control = 3'b000; src_a = 1'b0;
        op_a = 32'd0; op_b = 32'd0; flush = 1'b0;
        repeat (3) @(negedge clk);
        check("rst out_valid", 64'(out_valid), 64'd0);
        check("rst result", 64'(result), 64'd0);
        check("rst flags", 64'(flags), 64'd0);
        check("rst illegal", 64'(illegal), 64'd0);
        check("rst in_ready", 64'(in_ready), 64'd1);
        check("rst stall", 64'(stall_o), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 14; i++) begin
            do_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].sa,
                  vecs[i].res, vecs[i].flg, vecs[i].ill, vecs[i].lat, vecs[i].nm);
        end

        // MUL followed by an ADD held during the busy cycle.
        in_valid = 1'b1; alu_control = 3'b100; src_a = 1'b0; op_a = 32'h0001_0000; op_b = 32'h0001_0003;
        @(negedge clk);
        check("mulseq ready_T1", 64'(in_ready), 64'd0);
        check("mulseq outv_T1", 64'(out_valid), 64'd0);
        alu_control = 3'b000; op_a = 32'd2; op_b = 32'd3;
        @(negedge clk);
        check("mulseq outv_T2", 64'(out_valid), 64'd1);
        check("mulseq res_T2", 64'(result), 64'h0003_0000);
        check("mulseq ready_T2", 64'(in_ready), 64'd1);
        @(negedge clk);
        in_valid = 1'b0;
        check("mulseq add_outv", 64'(out_valid), 64'd1);
        check("mulseq add_res", 64'(result), 64'd5);
        @(negedge clk);
        check("mulseq pulse_end", 64'(out_valid), 64'd0);

        // Flush two cycles into a CONV.
        in_valid = 1'b1; alu_control = 3'b101; op_a = 32'h1020_3040; op_b = 32'h0102_0304;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("convflush ready_T3", 64'(in_ready), 64'd1);
        seen = out_valid;
        repeat (6) begin
            @(negedge clk);
            seen = seen | out_valid;
        end
        check("convflush no_outv", 64'(seen), 64'd0);

        // Flush in the cycle a MUL result would register.
        in_valid = 1'b1; alu_control = 3'b100; op_a = 32'd6; op_b = 32'd7;
        @(negedge clk);
        in_valid = 1'b0; flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("mulflush outv", 64'(out_valid), 64'd0);
        check("mulflush ready", 64'(in_ready), 64'd1);
        check("mulflush res_kept", 64'(result), 64'd5);

        // Flush alongside in_valid drops the input.
        in_valid = 1'b1; alu_control = 3'b000; op_a = 32'd1; op_b = 32'd1; flush = 1'b1;
        @(negedge clk);
        in_valid = 1'b0; flush = 1'b0;
        check("flushin outv", 64'(out_valid), 64'd0);
        @(negedge clk);
        check("flushin outv_late", 64'(out_valid), 64'd0);

        // Reset asserted mid-CONV after a non-zero result.
        do_op(3'b000, 32'd40, 32'd2, 1'b0, 32'd42, 4'b0000, 1'b0, 1, "pre_rst_add");
        in_valid = 1'b1; alu_control = 3'b101; op_a = 32'hFFFF_FFFF; op_b = 32'h7F7F_7F7F;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        check("midrst stall_before", 64'(stall_o), 64'd1);
        rst_n = 1'b0;
        #1;
        check("midrst result", 64'(result), 64'd0);
        check("midrst flags", 64'(flags), 64'd0);
        check("midrst ready", 64'(in_ready), 64'd1);
        check("midrst stall", 64'(stall_o), 64'd0);
        check("midrst outv", 64'(out_valid), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            seen = seen | out_valid;
        end
        check("midrst no_outv", 64'(seen), 64'd0);

        // Random traffic against the model.
        for (int n = 0; n < 150; n++) begin
            case ($urandom_range(0, 9))
                0, 1, 2: op = 3'b000;
                3, 4:    op = 3'b011;
                5:       op = 3'b100;
                6, 7:    op = 3'b101;
                default: op = ill_ops[$urandom_range(0, 3)];
            endcase
            a  = pick_operand();
            b  = pick_operand();
            sa = ($urandom_range(0, 3) == 0);
            model(op, a, b, sa, er, ef, ei, lat);
            do_op(op, a, b, sa, er, ef, ei, lat, $sformatf("rnd%0d op%0d", n, op));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
- Execute-stage ALU of the Filter-GPU. It sits directly downstream of the control unit's ALU decoder.
- Consumes the decoder's 3-bit ALUControl and SrcA select, plus two register operands.
- Performs ADD/MOV/SUB in a single cycle, MUL over two cycles and CONV as a multi-cycle per-lane multiply-accumulate with pixel saturation.
- Raises stall_o toward the pipeline while a multi-cycle operation is in flight.

Parameters:
- WIDTH, 32: operand/result width.
- LANE_W, 8: CONV lane width. WIDTH must be a multiple of LANE_W.
- SHIFT, 4: CONV normalisation, as an arithmetic right shift applied before saturation.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operation presented this cycle.
- in_ready  out  1  unit can accept this cycle.
- alu_control  in  3  000 ADD, 011 SUB, 100 MUL, 101 CONV; all others illegal.
- src_a  in  1  1 forces operand A to zero (MOV = ADD with src_a=1).
- op_a  in  WIDTH  operand A. For CONV: unsigned pixels, lane i = bits [i*LANE_W +: LANE_W].
- op_b  in  WIDTH  operand B. For CONV: signed kernel coefficients, same lane packing.
- flush  in  1  synchronous abort of the current/accepted operation.
- out_valid  out  1  one-cycle pulse, result valid.
- result  out  WIDTH  registered result.
- flags  out  4  {N,Z,C,V}, registered with result.
- illegal  out  1  pulses with out_valid for an unsupported alu_control.
- stall_o  out  1  equal to ~in_ready.

Behaviour:
- Reset (async, rst_n=0): state IDLE; lane counter and accumulator 0; out_valid=0, result=0, flags=0, illegal=0, in_ready=1, stall_o=0.
- Derived constants: LANES=WIDTH/LANE_W. Accumulator is signed, ACC_W = 2*LANE_W + clog2(LANES) + 1 bits (19 for defaults).
- Accept condition: in_valid & in_ready & ~flush. The accept cycle is T. Operands are captured at the edge ending T.
- State IDLE, in_ready=1:
  - ADD/SUB/illegal: result in T+1; stay IDLE. Back-to-back accepts are allowed.
  - MUL: go to MUL.
  - CONV: go to CONV with lane counter 0 and accumulator 0.
- ADD:
  - Computes A'+B, where A' = src_a ? 0 : op_a.
  - C = carry-out; V = signed overflow.
- SUB:
  - Computes A'-B (src_a still honoured).
  - C = NOT borrow, ARM convention; V = signed overflow.
- MUL:
  - State MUL holds one cycle, in_ready=0.
  - result = low WIDTH bits of A'*B, out_valid in T+2.
  - Flags: N and Z from result; C=V=0. Returns to IDLE.
- CONV:
  - Each CONV cycle adds zero-extended pixel lane[k] times sign-extended coefficient lane[k] to the accumulator, then k++.
  - After k = LANES-1, go to SAT.
  - SAT: acc >>> SHIFT, clamp to [0, 2^LANE_W - 1], zero-extend to WIDTH, register as result.
  - out_valid in T+LANES+1 (T+5 for defaults). in_ready=0 from T+1 through the SAT cycle.
  - Flags: Z only; N=C=V=0. src_a is ignored.
- Illegal opcode: result=0, flags=0, illegal=1, out_valid in T+1.
- flush:
  - Return to IDLE next edge and clear the counter.
  - No out_valid for the aborted op.
  - flush with in_valid in the same cycle: the input is dropped.
  - flush in the cycle a result would register: that result is suppressed.
- out_valid has no backpressure. The downstream stage must sample it in the pulse cycle.
- Reset asserted mid-operation: immediate return to the reset values; the in-flight op is lost.

Decomposition:
- Package gpu_alu_pkg:
  - alu_op_e enum: ADD=3'b000, SUB=3'b011, MUL=3'b100, CONV=3'b101.
  - exec_state_e: IDLE, MUL, CONV, SAT.
  - FLAG_N/Z/C/V bit indices.
- One sub-module, conv_mac:
  - Lane select by counter, signed MAC into the accumulator, clear/enable inputs.
  - Saturate/shift output, parameterised by LANE_W, LANES, SHIFT.

Test Plan:
- ADD overflow: op_a=0x7FFFFFFF, op_b=1, src_a=0 -> T+1: result 0x80000000, flags N=1 Z=0 C=0 V=1.
- SUB equal/MOV: SUB 5-5 -> result 0, Z=1 C=1. MOV (ADD, src_a=1, op_a=0x1234, op_b=0xDEADBEEF) -> result 0xDEADBEEF, N=1.
- MUL: op_a=0x00010000, op_b=0x00010003 -> T+2: result 0x00030000, in_ready=0 at T+1. A new ADD held at T+1 is accepted at T+2.
- CONV nominal: op_a=0x10203040, op_b=0x01020304 -> acc 480 -> result 0x1E at T+5, stall_o high T+1..T+4.
- CONV saturation:
  - op_a=0xFFFFFFFF, op_b=0x7F7F7F7F -> result 0xFF.
  - op_a=0x01010101, op_b=0xFFFFFFFF -> acc -4 -> result 0x00.
- Flush/illegal:
  - flush at T+2 of a CONV -> no out_valid, in_ready=1 at T+3.
  - alu_control=3'b110 -> T+1: out_valid=1, illegal=1, result 0.
  - rst_n pulled low mid-CONV -> outputs return to reset values immediately.
